// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq: multi-cycle MULTU/DIVU sequencer that drives a shared
// MIPS ALU (add/subtract) one step per clock. Multiply is shift-add, divide
// is restoring. Results are written to architectural HI/LO registers.
// The ALU drive (alu_a/alu_b/alu_ctrl) is registered: each cycle it is
// computed from the working-register values being loaded, so it always
// equals the combinational function of acc/q/m that the current step needs.
module mips_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
    localparam logic [2:0]      CTRL_ADD = 3'b010;
    localparam logic [2:0]      CTRL_SUB = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIN  = 2'b11
    } state_t;

    // Restoring-divide partial remainder shifted left by one with the next
    // dividend bit brought in from the top of q.
    function automatic logic [WIDTH-1:0] div_shift(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        div_shift = {a[WIDTH-2:0], b[WIDTH-1]};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] opa_cap_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [2:0]       alu_ctrl_r;

    logic [WIDTH-1:0] mul_s_s;
    logic             mul_c_s;
    logic [WIDTH-1:0] div_sh_s;
    logic             div_qb_s;
    logic [WIDTH-1:0] acc_step_s;
    logic [WIDTH-1:0] q_step_s;
    logic [WIDTH-1:0] next_a_s;

    // One iteration of the current algorithm, using the ALU's answer.
    always_comb begin
        mul_s_s    = q_r[0] ? alu_result : acc_r;
        mul_c_s    = q_r[0] ? alu_cout : 1'b0;
        div_sh_s   = div_shift(acc_r, q_r);
        div_qb_s   = acc_r[WIDTH-1] | alu_cout;
        acc_step_s = acc_r;
        q_step_s   = q_r;
        case (state_r)
            MUL: begin
                acc_step_s = {mul_c_s, mul_s_s[WIDTH-1:1]};
                q_step_s   = {mul_s_s[0], q_r[WIDTH-1:1]};
            end
            DIV: begin
                acc_step_s = div_qb_s ? alu_result : div_sh_s;
                q_step_s   = {q_r[WIDTH-2:0], div_qb_s};
            end
            default: begin
                acc_step_s = acc_r;
                q_step_s   = q_r;
            end
        endcase
        if (state_r == DIV) begin
            next_a_s = div_shift(acc_step_s, q_step_s);
        end else begin
            next_a_s = acc_step_s;
        end
    end

    // Sequencer FSM, working registers, HI/LO and registered ALU drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            acc_r      <= ZERO;
            q_r        <= ZERO;
            m_r        <= ZERO;
            opa_cap_r  <= ZERO;
            cnt_r      <= CNT_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
            hi_r       <= ZERO;
            lo_r       <= ZERO;
            alu_a_r    <= ZERO;
            alu_b_r    <= ZERO;
            alu_ctrl_r <= CTRL_ADD;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r     <= ZERO;
                        cnt_r     <= CNT_ZERO;
                        opa_cap_r <= opa;
                        busy_r    <= 1'b1;
                        if (!op) begin
                            state_r    <= MUL;
                            q_r        <= opb;
                            m_r        <= opa;
                            dbz_r      <= 1'b0;
                            alu_a_r    <= ZERO;
                            alu_b_r    <= opa;
                            alu_ctrl_r <= CTRL_ADD;
                        end else if (opb != ZERO) begin
                            state_r    <= DIV;
                            q_r        <= opa;
                            m_r        <= opb;
                            dbz_r      <= 1'b0;
                            alu_a_r    <= div_shift(ZERO, opa);
                            alu_b_r    <= opb;
                            alu_ctrl_r <= CTRL_SUB;
                        end else begin
                            state_r    <= FIN;
                            q_r        <= opa;
                            m_r        <= opb;
                            dbz_r      <= 1'b1;
                            alu_a_r    <= ZERO;
                            alu_b_r    <= ZERO;
                            alu_ctrl_r <= CTRL_ADD;
                        end
                    end else begin
                        busy_r     <= 1'b0;
                        alu_a_r    <= ZERO;
                        alu_b_r    <= ZERO;
                        alu_ctrl_r <= CTRL_ADD;
                    end
                end
                MUL, DIV: begin
                    acc_r <= acc_step_s;
                    q_r   <= q_step_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r    <= FIN;
                        alu_a_r    <= ZERO;
                        alu_b_r    <= ZERO;
                        alu_ctrl_r <= CTRL_ADD;
                    end else begin
                        alu_a_r <= next_a_s;
                        alu_b_r <= m_r;
                    end
                end
                FIN: begin
                    if (dbz_r) begin
                        hi_r <= opa_cap_r;
                        lo_r <= ONES;
                    end else begin
                        hi_r <= acc_r;
                        lo_r <= q_r;
                    end
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    alu_a_r    <= ZERO;
                    alu_b_r    <= ZERO;
                    alu_ctrl_r <= CTRL_ADD;
                end
                default: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    alu_a_r    <= ZERO;
                    alu_b_r    <= ZERO;
                    alu_ctrl_r <= CTRL_ADD;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_ctrl    = alu_ctrl_r;

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// tb_mips_muldiv_seq: directed bench for the MULTU/DIVU sequencer with a
// behavioural add/subtract ALU and a queue of expected results.
module tb_mips_muldiv_seq;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] alu_result;
    logic         alu_cout;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp;
    int           n_bad;
    logic [W-1:0] prev_hi;
    logic [W-1:0] prev_lo;

    mips_muldiv_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .opa        (opa),
        .opb        (opb),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: 010 add, 110 subtract (a + ~b + 1, carry = a >= b).
    always_comb begin
        if (alu_ctrl == 3'b110) begin
            {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        end else begin
            {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive a request (sampled at the next edge) and queue its expected result.
    task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        if (!o) begin
            p     = {32'd0, a} * {32'd0, b};
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.dbz = 1'b0;
            e.lat = W + 1;
        end else if (b == 32'd0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.hi  = a % b;
            e.lo  = a / b;
            e.dbz = 1'b0;
            e.lat = W + 1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_at_accept", {63'd0, busy}, 64'd1);
        chk("dbz_at_accept", {63'd0, div_by_zero}, {63'd0, e.dbz});
        chk("alu_ctrl_at_accept", {61'd0, alu_ctrl},
            (o && b != 32'd0) ? 64'd6 : 64'd2);
        chk("alu_b_at_accept", {32'd0, alu_b},
            {32'd0, (!o) ? a : b});
    endtask

    // Wait for done, checking busy and HI/LO hold; optionally inject a
    // start with junk operands while the operation is in flight.
    task automatic wait_done(input string tag, input int inj);
        int   n;
        logic got;
        exp_t e;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == inj) begin
                start = 1'b1;
                op    = 1'b1;
                opa   = 32'hDEAD_BEEF;
                opb   = 32'h0000_0003;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got = 1'b1;
            end else begin
                chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
                chk({tag, "_hi_hold"}, {32'd0, hi}, {32'd0, prev_hi});
                chk({tag, "_lo_hold"}, {32'd0, lo}, {32'd0, prev_lo});
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, {63'd0, got}, 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, n, e.lat);
            chk({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
            chk({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
            chk({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
            chk({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
            prev_hi = e.hi;
            prev_lo = e.lo;
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        reset   = 1'b0;
        start   = 1'b0;
        op      = 1'b0;
        opa     = 32'd0;
        opb     = 32'd0;
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
        chk("rst_alu_b", {32'd0, alu_b}, 64'd0);
        chk("rst_alu_ctrl", {61'd0, alu_ctrl}, 64'd2);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Multiply cases
        issue(1'b0, 32'd7, 32'd6);
        wait_done("mul_7x6", 0);
        @(negedge clk);
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mul_max", 0);
        @(negedge clk);
        issue(1'b0, 32'h8000_0000, 32'd2);
        wait_done("mul_msb_x2", 0);

        // Divide cases
        @(negedge clk);
        issue(1'b1, 32'd100, 32'd7);
        wait_done("div_100_7", 0);
        @(negedge clk);
        issue(1'b1, 32'hFFFF_FFFF, 32'd1);
        wait_done("div_max_1", 0);
        @(negedge clk);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_msb_max", 0);

        // Divide by zero, then a multiply that clears the sticky flag
        @(negedge clk);
        issue(1'b1, 32'd5, 32'd0);
        wait_done("div_by_zero", 0);
        @(negedge clk);
        issue(1'b0, 32'd3, 32'd3);
        wait_done("mul_3x3", 0);

        // Ignored start mid-operation, then back-to-back start in done cycle
        @(negedge clk);
        issue(1'b0, 32'd7, 32'd6);
        wait_done("mul_ignore_start", 10);
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_done("mul_back_to_back", 0);
        issue(1'b1, 32'hCAFE_F00D, 32'h0001_0003);
        wait_done("div_back_to_back", 0);

        // Asynchronous reset mid-divide
        @(negedge clk);
        issue(1'b1, 32'd100, 32'd7);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_hi", {32'd0, hi}, 64'd0);
        chk("midrst_lo", {32'd0, lo}, 64'd0);
        chk("midrst_alu_a", {32'd0, alu_a}, 64'd0);
        if (sb.size() != 0) begin
            void'(sb.pop_front());
        end
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            chk("postrst_no_done", {63'd0, done}, 64'd0);
            chk("postrst_idle", {63'd0, busy}, 64'd0);
        end
        @(negedge clk);
        issue(1'b1, 32'd9, 32'd3);
        wait_done("div_9_3", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
